// File: rtl/shift_result_tx_pkg.sv
// -----------------------------------------------------------------------------
// shift_result_tx_pkg
// Shared types and constants for the shift_result_tx serial transmitter:
//   - FSM state type (the PARITY state exists only when
//     SHIFT_RESULT_TX_PARITY_EN is defined)
//   - frame-length constants
//   - bit positions of the fields packed into ui_in / uo_out
// Macro: SHIFT_RESULT_TX_PARITY_EN (adds an even-parity bit, 11-bit frame)
// -----------------------------------------------------------------------------
package shift_result_tx_pkg;

`ifdef SHIFT_RESULT_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int FRAME_BITS = 11;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
  localparam int FRAME_BITS = 10;
`endif

  localparam int         DATA_BITS    = 8;
  localparam int         NIB_W        = 4;
  localparam logic [2:0] LAST_BIT_IDX = 3'd7;

  // ui_in field positions ([3:0] is the nibble)
  localparam int UI_WR_LO = 4;
  localparam int UI_WR_HI = 5;
  localparam int UI_SEND  = 6;
  localparam int UI_TICK  = 7;

  // uo_out field positions
  localparam int UO_TXD         = 0;
  localparam int UO_BUSY        = 1;
  localparam int UO_PENDING     = 2;
  localparam int UO_DONE        = 3;
  localparam int UO_OVERRUN     = 4;
  localparam int UO_BIT_IDX_LSB = 5;

endpackage

// File: rtl/shift_result_tx_hold.sv
// -----------------------------------------------------------------------------
// shift_result_tx_hold
// Holding register, pending flag and sticky overrun flag.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_nibble        nibble written into hold
//   i_wr_lo/i_wr_hi write nibble into hold[3:0] / hold[7:4] (only while idle)
//   i_send          request transmission of hold
//   i_transfer      FSM copies hold into its shift register this cycle
//   o_hold          holding register contents
//   o_pending       a send request is waiting for the FSM
//   o_overrun       sticky: a send was dropped because one was already waiting
// -----------------------------------------------------------------------------
module shift_result_tx_hold
  import shift_result_tx_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NIB_W-1:0]     i_nibble,
  input  logic                 i_wr_lo,
  input  logic                 i_wr_hi,
  input  logic                 i_send,
  input  logic                 i_transfer,
  output logic [DATA_BITS-1:0] o_hold,
  output logic                 o_pending,
  output logic                 o_overrun
);

  logic [DATA_BITS-1:0] r_hold;
  logic                 r_pending;
  logic                 r_overrun;
  logic                 w_accept;
  logic                 w_drop;

  // A send is accepted when nothing is waiting, or when the waiting request
  // is leaving for the shifter on this very edge.
  assign w_accept = i_send & (~r_pending | i_transfer);
  assign w_drop   = i_send & r_pending & ~i_transfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold    <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // hold is frozen while a request is waiting so the queued byte is stable
      if (!r_pending) begin
        if (i_wr_lo) r_hold[3:0] <= i_nibble;
        if (i_wr_hi) r_hold[7:4] <= i_nibble;
      end
      if (w_accept)        r_pending <= 1'b1;
      else if (i_transfer) r_pending <= 1'b0;
      if (w_drop)          r_overrun <= 1'b1;
    end
  end

  assign o_hold    = r_hold;
  assign o_pending = r_pending;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/shift_result_tx.sv
// -----------------------------------------------------------------------------
// shift_result_tx
// Byte-wide serial transmitter: start bit (0), 8 data bits MSB first,
// optional even-parity bit, stop bit (1). Bit rate set by the tick enable.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   ui_in   [3:0] nibble, [4] wr_lo, [5] wr_hi, [6] send, [7] tick
//   uo_out  [0] txd, [1] busy, [2] pending, [3] done, [4] overrun,
//           [7:5] bit_idx
// Macro: SHIFT_RESULT_TX_PARITY_EN adds the PARITY state (11-bit frame).
// -----------------------------------------------------------------------------
module shift_result_tx
  import shift_result_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  state_t               r_state;
  state_t               w_state_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [2:0]           r_bit_idx;
  logic                 r_done;
  logic [DATA_BITS-1:0] w_hold;
  logic                 w_pending;
  logic                 w_overrun;
  logic                 w_transfer;
  logic                 w_tick;
  logic                 w_txd;
`ifdef SHIFT_RESULT_TX_PARITY_EN
  logic                 r_parity;
`endif

  assign w_tick = ui_in[UI_TICK];

  // Loading the shifter is not paced by tick, so a waiting byte starts its
  // frame one cycle after the FSM reaches IDLE.
  assign w_transfer = (r_state == IDLE) & w_pending;

  shift_result_tx_hold u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_nibble   (ui_in[NIB_W-1:0]),
    .i_wr_lo    (ui_in[UI_WR_LO]),
    .i_wr_hi    (ui_in[UI_WR_HI]),
    .i_send     (ui_in[UI_SEND]),
    .i_transfer (w_transfer),
    .o_hold     (w_hold),
    .o_pending  (w_pending),
    .o_overrun  (w_overrun)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (w_pending) w_state_next = START;
      START: if (w_tick)    w_state_next = DATA;
      DATA: begin
        if (w_tick && (r_bit_idx == LAST_BIT_IDX)) begin
`ifdef SHIFT_RESULT_TX_PARITY_EN
          w_state_next = PARITY;
`else
          w_state_next = STOP;
`endif
        end
      end
`ifdef SHIFT_RESULT_TX_PARITY_EN
      PARITY: if (w_tick) w_state_next = STOP;
`endif
      STOP:  if (w_tick)    w_state_next = IDLE;
      default:              w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_done    <= 1'b0;
`ifdef SHIFT_RESULT_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == STOP) && w_tick;
      if (w_transfer) begin
        r_shift  <= w_hold;
`ifdef SHIFT_RESULT_TX_PARITY_EN
        // captured up front because the shifter destroys the byte
        r_parity <= ^w_hold;
`endif
      end
      if (r_state == START) begin
        r_bit_idx <= '0;
      end else if ((r_state == DATA) && w_tick) begin
        r_shift   <= r_shift << 1;
        // 3-bit counter wraps 7 -> 0, leaving bit_idx at 0 outside DATA
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  always_comb begin
    w_txd = 1'b1;
    case (r_state)
      START:  w_txd = 1'b0;
      DATA:   w_txd = r_shift[DATA_BITS-1];
`ifdef SHIFT_RESULT_TX_PARITY_EN
      PARITY: w_txd = r_parity;
`endif
      default: w_txd = 1'b1;
    endcase
  end

  assign uo_out[UO_TXD]                 = w_txd;
  assign uo_out[UO_BUSY]                = (r_state != IDLE);
  assign uo_out[UO_PENDING]             = w_pending;
  assign uo_out[UO_DONE]                = r_done;
  assign uo_out[UO_OVERRUN]             = w_overrun;
  assign uo_out[UO_BIT_IDX_LSB +: 3]    = r_bit_idx;

endmodule

// File: tb/tb_shift_result_tx.sv
`timescale 1ns/1ps
module tb_shift_result_tx;
  import shift_result_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] nib = 4'h0;
  logic       wr_lo = 1'b0, wr_hi = 1'b0, send = 1'b0, tick = 1'b0;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  assign ui_in = {tick, send, wr_hi, wr_lo, nib};

  shift_result_tx dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .uo_out (uo_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tick_div = 0;
  int tick_cnt = 0;
  logic [7:0]  exp_q[$];
  int          frames_seen = 0;
  logic [10:0] last_frame = '0;
  int          last_gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard (samples on falling edge) ----------
  logic [10:0] m_bits = '0;
  logic [7:0]  m_data;
  logic        m_cur = 1'b1;
  bit          m_have = 1'b0;
  int          m_n = 0, m_len = 0, m_idle = 100, done_state = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_bits = '0; m_n = 0; m_len = 0; m_have = 1'b0;
      done_state = 0; m_idle = 100;
      exp_q.delete();
    end else begin
      if (done_state == 1) begin
        check("done_pulse", uo_out[UO_DONE], 1);
        done_state = 2;
      end else if (done_state == 2) begin
        check("done_width", uo_out[UO_DONE], 0);
        done_state = 0;
      end else if (uo_out[UO_DONE]) begin
        check("done_spurious", uo_out[UO_DONE], 0);
      end

      if (!uo_out[UO_BUSY]) begin
        if (m_n != 0) begin
          check("frame_cut", m_n, 0);
          m_n = 0; m_bits = '0;
        end
        m_idle++;
        m_have = 1'b0;
        m_len = 0;
      end else begin
        if (m_idle > 0) begin
          last_gap = m_idle;
          m_idle = 0;
        end
        if (!m_have) begin
          m_cur = uo_out[UO_TXD];
          m_have = 1'b1;
        end else begin
          check("bit_stable", uo_out[UO_TXD], m_cur);
        end
        m_len++;
        if (tick) begin
          check("bit_idx", uo_out[7:5], (m_n >= 1 && m_n <= 8) ? m_n - 1 : 0);
          if (m_n > 0 && tick_div > 0) check("bit_len", m_len, tick_div);
          m_bits = {m_bits[9:0], m_cur};
          m_n++;
          m_len = 0;
          m_have = 1'b0;
          if (m_n == FRAME_BITS) begin
            last_frame = m_bits;
            frames_seen++;
`ifdef SHIFT_RESULT_TX_PARITY_EN
            m_data = m_bits[9:2];
            check("parity_bit", m_bits[1], ^m_data);
`else
            m_data = m_bits[8:1];
`endif
            check("start_bit", m_bits[FRAME_BITS-1], 0);
            check("stop_bit", m_bits[0], 1);
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL sb_empty actual=%0h required=no_frame", m_data);
            end else begin
              check("sb_byte", m_data, exp_q.pop_front());
            end
            $display("frame %0d: byte=%0h bits=%0b", frames_seen, m_data, m_bits);
            done_state = 1;
            m_n = 0;
            m_bits = '0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
    wr_lo = 1'b0; wr_hi = 1'b0; send = 1'b0;
    if (tick_div <= 0) begin
      tick = 1'b0;
    end else begin
      tick_cnt = (tick_cnt + 1) % tick_div;
      tick = (tick_cnt == 0);
    end
  endtask

  task automatic load(input logic [7:0] b);
    nib = b[3:0]; wr_lo = 1'b1; cyc();
    nib = b[7:4]; wr_hi = 1'b1; cyc();
  endtask

  task automatic send_byte(input logic [7:0] b);
    send = 1'b1;
    exp_q.push_back(b);
    cyc();
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_seen < target && n < budget) begin
      cyc();
      n++;
    end
    if (frames_seen < target) check("frame_timeout", frames_seen, target);
  endtask

  typedef struct {
    logic [7:0]  data;
    int          div;
    logic [9:0]  exp_np;
    logic [10:0] exp_p;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int f0;
    int n;
    vecs[0] = '{8'hA5, 1, 10'b0101001011, 11'b01010010101};
    vecs[1] = '{8'h07, 1, 10'b0000001111, 11'b00000011111};
    vecs[2] = '{8'h3C, 4, 10'b0001111001, 11'b00011110001};
    vecs[3] = '{8'h00, 2, 10'b0000000001, 11'b00000000001};
    vecs[4] = '{8'hFF, 3, 10'b0111111111, 11'b01111111101};

    // reset state
    @(negedge clk);
    check("reset_uo", uo_out, 8'h01);
    rst_n = 1'b1;
    cyc();
    check("post_reset_uo", uo_out, 8'h01);

    // table-driven frames
    for (int i = 0; i < 5; i++) begin
      tick_div = vecs[i].div;
      tick_cnt = 0;
      load(vecs[i].data);
      check("pending_before_send", uo_out[UO_PENDING], 0);
      f0 = frames_seen;
      send_byte(vecs[i].data);
      check("pending_after_send", uo_out[UO_PENDING], 1);
      wait_frames(f0 + 1, 200);
      repeat (3) cyc();
`ifdef SHIFT_RESULT_TX_PARITY_EN
      check("frame_bits", last_frame, {21'd0, vecs[i].exp_p});
`else
      check("frame_bits", last_frame, {22'd0, vecs[i].exp_np});
`endif
      check("overrun_clear", uo_out[UO_OVERRUN], 0);
    end

    // write while pending is ignored; hold keeps its contents for a resend
    tick_div = 1; tick_cnt = 0;
    load(8'h5A);
    f0 = frames_seen;
    send_byte(8'h5A);
    nib = 4'hF; wr_lo = 1'b1; cyc();
    wait_frames(f0 + 1, 100);
    repeat (3) cyc();
    send_byte(8'h5A);
    wait_frames(f0 + 2, 100);
    repeat (3) cyc();

    // back-to-back with a queued byte and a dropped send
    tick_div = 0; tick_cnt = 0;
    load(8'h11);
    f0 = frames_seen;
    send_byte(8'h11);
    cyc();
    check("start_busy", uo_out[UO_BUSY], 1);
    check("start_txd", uo_out[UO_TXD], 0);
    check("start_pending", uo_out[UO_PENDING], 0);
    load(8'h22);
    check("start_held", uo_out[UO_TXD], 0);
    send_byte(8'h22);
    check("queued_pending", uo_out[UO_PENDING], 1);
    check("overrun_before_drop", uo_out[UO_OVERRUN], 0);
    send = 1'b1; cyc();
    check("overrun_set", uo_out[UO_OVERRUN], 1);
    nib = 4'hF; wr_lo = 1'b1; cyc();
    tick_div = 1; tick_cnt = 0; tick = 1'b1;
    wait_frames(f0 + 2, 100);
    check("idle_gap", last_gap, 1);
    repeat (3) cyc();
    check("overrun_sticky", uo_out[UO_OVERRUN], 1);

    // reset in the middle of DATA
    tick_div = 1; tick_cnt = 0;
    load(8'h96);
    f0 = frames_seen;
    send_byte(8'h96);
    n = 0;
    while (!(uo_out[UO_BUSY] && uo_out[7:5] == 3'd3) && n < 50) begin
      cyc();
      n++;
    end
    check("reach_data3", {uo_out[UO_BUSY], uo_out[7:5]}, 4'b1011);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", uo_out, 8'h01);
    repeat (2) cyc();
    check("reset_held", uo_out, 8'h01);
    #3;
    rst_n = 1'b1;
    repeat (15) cyc();
    check("after_reset_uo", uo_out, 8'h01);
    check("no_frame_after_reset", frames_seen, f0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_result_tx.md
SHIFT_RESULT_TX -- requirements
Module: shift_result_tx

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port ui_in, input, 8 bits: [3:0] nibble data; [4] wr_lo; [5] wr_hi; [6] send; [7] tick (bit-rate enable).
REQ-004 SHALL have port uo_out, output, 8 bits: [0] txd; [1] busy; [2] pending; [3] done; [4] overrun; [7:5] bit_idx.

Function
REQ-005 SHALL hold an 8-bit holding register (hold) and a pending flag; wr_lo=1 writes ui_in[3:0] to hold[3:0], and wr_hi=1 writes ui_in[3:0] to hold[7:4], on the clock edge, only when pending=0.
REQ-006 SHALL set pending on send=1 when pending=0 or when hold transfers to the shift register in the same cycle; hold keeps its contents.
REQ-007 SHALL, on send=1 while pending=1 with no transfer that cycle, drop the request and set sticky overrun; overrun clears only on reset.
REQ-008 SHALL use FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-009 IDLE: txd=1; if pending=1, on the next edge copy hold to the 8-bit shift register, clear pending (unless REQ-006 re-sets it), enter START; this transfer SHALL NOT require tick.
REQ-010 START: txd=0; on tick=1 go to DATA with bit_idx=0.
REQ-011 DATA: txd=shift[7] (MSB first); on tick=1 shift left by 1 and increment bit_idx; on the tick with bit_idx=7 go to PARITY if enabled, else STOP.
REQ-012 STOP: txd=1; on tick=1 return to IDLE and assert done for exactly one clock cycle, the cycle following that edge.
REQ-013 SHALL hold each non-IDLE state with its output unchanged while tick=0; each serial bit lasts from one accepted tick to the next.
REQ-014 busy SHALL be 1 in every state except IDLE; pending SHALL mirror the pending flag; bit_idx SHALL be the data bit index in DATA and 0 in all other states.
REQ-015 All uo_out bits SHALL be driven from registers only, with no combinational path from ui_in.
REQ-016 Back-to-back: with pending=1 when STOP exits, the next frame's START SHALL begin after exactly one IDLE cycle.

Reset
REQ-017 rst_n=0 SHALL asynchronously set state=IDLE, and clear hold, shift, pending, bit_idx, done and overrun to 0.
REQ-018 During and after reset, uo_out SHALL read 8'h01 (txd idle high); a frame in flight SHALL be abandoned with no done pulse.

Configuration
REQ-019 Macro SHIFT_RESULT_TX_PARITY_EN: when defined, PARITY state is included, with txd = XOR of the 8 data bits (even parity), left on tick=1 to STOP; frame is 11 bits.
REQ-020 Without SHIFT_RESULT_TX_PARITY_EN, the PARITY state and its logic SHALL be absent; frame is 10 bits.

Structure
REQ-021 Package shift_result_tx_pkg SHALL hold the FSM state type, frame-length constants, and uo_out bit-position constants.
REQ-022 The holding register, pending flag and overrun logic SHALL form one sub-module, shift_result_tx_hold; the FSM and shifter stay in the top.

Verification
REQ-023 Reset: assert rst_n=0 mid-DATA -> uo_out=8'h01 immediately, and done never pulses.
REQ-024 Load 0xA5 (wr_lo with nibble 5, wr_hi with nibble A), send, tick=1 every cycle, no parity -> txd 0,1,0,1,0,0,1,0,1,1, then done=1 for one cycle.
REQ-025 Same as REQ-024 with SHIFT_RESULT_TX_PARITY_EN -> txd 0,1,0,1,0,0,1,0,1,0,1; with 0x07 the parity bit is 1.
REQ-026 tick=1 only every 4th cycle, byte 0x3C -> each bit held 4 cycles, and bit_idx steps 0..7 during DATA.
REQ-027 Send 0x11; during its START, load 0x22 and send; send again before transfer -> frames 0x11 then 0x22 sent with one IDLE cycle between them, and overrun=1.
REQ-028 wr_lo with nibble F while pending=1 -> hold unchanged, and transmitted byte equals the value loaded before send.
